// File: rtl/shared_dmem_responder.sv
// Shared data-memory responder: round-robin arbitration across cores, one
// transaction at a time through IDLE -> ACCESS -> RESP.
module shared_dmem_responder #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 8,
    parameter int DW        = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CORES-1:0]    i_req,
    input  logic [NUM_CORES-1:0]    i_wen,
    input  logic [NUM_CORES*AW-1:0] i_addr,
    input  logic [NUM_CORES*DW-1:0] i_wdata,
    output logic [NUM_CORES-1:0]    o_gnt,
    output logic [NUM_CORES-1:0]    o_done,
    output logic [DW-1:0]           o_rdata,
    output logic                    o_busy
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_rrPtr;
    logic [IW-1:0]         r_idx;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;
    logic                  r_wen;
    logic [DW-1:0]         r_mem [0:(2**AW)-1];

    logic                  w_found;
    logic [IW-1:0]         w_winner;
    logic [IW-1:0]         w_nextPtr;
    logic [NUM_CORES-1:0]  w_winOneHot;
    logic [NUM_CORES-1:0]  w_idxOneHot;

    // Scan from the highest offset down so the requester closest to r_rrPtr wins.
    always_comb begin : arbScan
        int j;
        j        = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            j = int'(r_rrPtr) + k;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (i_req[IW'(j)]) begin
                w_found  = 1'b1;
                w_winner = IW'(j);
            end
        end
    end

    assign w_nextPtr   = (w_winner == IW'(NUM_CORES - 1)) ? '0 : w_winner + 1'b1;
    assign w_winOneHot = NUM_CORES'(1) << w_winner;
    assign w_idxOneHot = NUM_CORES'(1) << r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_rrPtr <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            o_gnt   <= '0;
            o_done  <= '0;
            o_rdata <= '0;
            o_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= '0;
                    if (w_found) begin
                        r_idx   <= w_winner;
                        r_addr  <= i_addr[w_winner*AW +: AW];
                        r_wdata <= i_wdata[w_winner*DW +: DW];
                        r_wen   <= i_wen[w_winner];
                        r_rrPtr <= w_nextPtr;
                        o_gnt   <= w_winOneHot;
                        o_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_gnt  <= '0;
                    o_done <= w_idxOneHot;
                    if (!r_wen) begin
                        o_rdata <= r_mem[r_addr];
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    o_done  <= '0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_gnt   <= '0;
                    o_done  <= '0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM is never cleared; a write landing on a reset edge is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == S_ACCESS && r_wen) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
